// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, defaults and round-robin pick for the Booth multiplier scheduler
// Contents:
//   state_t   scheduler FSM states (IDLE, RUN, DONE)
//   DEF_WIDTH default operand width, DEF_NREQ default requester count
//   MAX_NREQ  widest request vector rr_pick can scan
//   rr_pick   index of the first set valid bit at or after ptr, wrapping modulo nreq
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ  = 4;
   localparam int MAX_NREQ  = 32;

   // Returns ptr when nothing is valid; callers qualify the pick with |valid.
   function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] valid,
                                           input int unsigned         ptr,
                                           input int unsigned         nreq);
      int unsigned idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned i = 0; i < MAX_NREQ; i++) begin
         idx = (ptr + i) % nreq;
         if (!found && (i < nreq) && valid[idx[4:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/booth_step_core.sv
// rtl/booth_step_core.sv - iterative radix-2 Booth datapath, one add/sub + arithmetic shift per clock
// Ports:
//   clk, rst_n  clock (rising edge), async active-low reset
//   start       load a/b and begin a new product (ignored state is overwritten)
//   a, b        multiplicand / multiplier, two's complement, WIDTH bits
//   done        high during the cycle whose clock edge performs the final step
//   product     2*WIDTH-bit signed product as it will look after that final step
module booth_step_core
   import booth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   // One guard bit on the accumulator so that negating -2^(WIDTH-1) cannot overflow.
   logic [WIDTH:0]   mcand;
   logic [WIDTH:0]   hi;
   logic [WIDTH-1:0] lo;
   logic             q;
   logic [CW-1:0]    cnt;
   logic             active;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   hi_nxt;
   logic [WIDTH-1:0] lo_nxt;

   always_comb begin
      sum = hi;
      case ({lo[0], q})
         2'b01:   sum = hi + mcand;
         2'b10:   sum = hi - mcand;
         default: sum = hi;
      endcase
      hi_nxt = {sum[WIDTH], sum[WIDTH:1]};
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
   end

   assign done    = active && (cnt == CW'(WIDTH - 1));
   assign product = {hi_nxt[WIDTH-1:0], lo_nxt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         q      <= 1'b0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         mcand  <= {a[WIDTH-1], a};
         hi     <= '0;
         lo     <= b;
         q      <= 1'b0;
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         q   <= lo[0];
         cnt <= cnt + 1'b1;
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/booth_mul_sched.sv
// rtl/booth_mul_sched.sv - round-robin scheduler sharing one Booth multiplier among NREQ requesters
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready per-requester operand handshake; req_ready is one-hot or zero, only in IDLE
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready product handshake; rsp_id and rsp_product held while rsp_valid
//   busy                high while an operation is in RUN or DONE
//   op_count            completed responses, wrapping (only with BOOTH_PERF_CNT_EN defined)
module booth_mul_sched
   import booth_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NREQ  = DEF_NREQ,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   output logic                  busy
`ifdef BOOTH_PERF_CNT_EN
   ,
   output logic [15:0]           op_count
`endif
);

   state_t             state;
   state_t             state_nxt;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     grant_id;
   logic               accept;
   logic               core_done;
   logic [2*WIDTH-1:0] core_product;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;

   assign grant_id = IDW'(rr_pick(MAX_NREQ'(req_valid), 32'(rr_ptr), NREQ));
   assign a_sel    = req_a[grant_id*WIDTH +: WIDTH];
   assign b_sel    = req_b[grant_id*WIDTH +: WIDTH];

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               req_ready = NREQ'(1) << grant_id;
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (core_done) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         rsp_id      <= '0;
         rsp_product <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rsp_id <= grant_id;
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
         end
         if (core_done) begin
            rsp_product <= core_product;
         end
      end
   end

   booth_step_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept),
      .a       (a_sel),
      .b       (b_sel),
      .done    (core_done),
      .product (core_product)
   );

`ifdef BOOTH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if ((state == DONE) && rsp_ready) begin
         op_count <= op_count + 16'd1;
      end
   end
`else
`endif

endmodule
